// File: rtl/vga_sync_timing_pkg.sv
// Shared 640x480@60 raster timing constants.
// The raster generator and the drawing logic both import this package, so
// screen-edge geometry and sync timing come from one set of numbers.
package vga_sync_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] coord_t;

  // Horizontal timing, in pixels
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  // Vertical timing, in lines
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 640x480@60 uses negative-going syncs
  localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;

  // Pin level for a sync pulse: asserted XOR polarity
  function automatic logic sync_level(input logic asserted, input bit active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_sync_timing_axis.sv
// sync_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 on en and wraps. active and sync are registered from the
// next count, so they change in the same clk as the count they describe.
//   clk, rst    clock, synchronous active-high reset
//   en          advance the count by one
//   count       current position
//   wrap        en is high and count is at TOTAL-1 (count goes to 0 next edge)
//   active      count < VISIBLE
//   sync        pin-level sync (polarity applied)
module sync_axis_counter
  import vga_sync_timing_pkg::*;
#(
  parameter int VISIBLE    = VGA_H_VISIBLE,
  parameter int FRONT      = VGA_H_FRONT,
  parameter int SYNC       = VGA_H_SYNC,
  parameter int BACK       = VGA_H_BACK,
  parameter bit ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync
);

  localparam int     TOTAL   = VISIBLE + FRONT + SYNC + BACK;
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t VIS_END = coord_t'(VISIBLE);
  localparam coord_t SYNC_LO = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_HI = coord_t'(VISIBLE + FRONT + SYNC);

  coord_t nxt;

  assign wrap = en && (count == LAST);

  always_comb begin
    nxt = count;
    if (en) nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
      sync   <= ACTIVE_LOW;
    end else begin
      count  <= nxt;
      active <= (nxt < VIS_END);
      sync   <= sync_level((nxt >= SYNC_LO) && (nxt < SYNC_HI), ACTIVE_LOW);
    end
  end

endmodule

// File: rtl/vga_sync_timing.sv
// vga_sync_timing: VGA raster timing from the system clock.
// A divider produces a one-clk pixel slot; a horizontal axis counter advances
// per slot and a vertical one advances on each horizontal wrap.
//   clk            system clock
//   Reset          synchronous active-high reset
//   pix_en         one-clk pulse per pixel slot (constant 1 when CLK_DIV=1)
//   CounterX/Y     raster position, held for CLK_DIV clks
//   inDisplayArea  position is inside the visible window
//   vga_h_sync     horizontal sync pin
//   vga_v_sync     vertical sync pin
//   line_start     one clk, the clk CounterX becomes 0
//   frame_start    one clk, the clk CounterX and CounterY both become 0
module vga_sync_timing
  import vga_sync_timing_pkg::*;
#(
  parameter int CLK_DIV         = 2,
  parameter int H_VISIBLE       = VGA_H_VISIBLE,
  parameter int H_FRONT         = VGA_H_FRONT,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BACK          = VGA_H_BACK,
  parameter int V_VISIBLE       = VGA_V_VISIBLE,
  parameter int V_FRONT         = VGA_V_FRONT,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BACK          = VGA_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
  input  logic       clk,
  input  logic       Reset,
  output logic       pix_en,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       inDisplayArea,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("vga_sync_timing: H_TOTAL/V_TOTAL do not fit the coordinate width");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_timing: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap, v_wrap;
  logic             h_active, v_active;

  // tick is the edge on which the counters move; pix_en is its registered
  // copy, so pix_en is high in the clk that shows the freshly updated position.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (Reset) begin
      div         <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + 1'b1;
      pix_en      <= tick;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

  sync_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_h (
    .clk(clk), .rst(Reset), .en(tick),
    .count(CounterX), .wrap(h_wrap), .active(h_active), .sync(vga_h_sync)
  );

  // h_wrap already includes tick, so the vertical axis moves once per line
  sync_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_v (
    .clk(clk), .rst(Reset), .en(h_wrap),
    .count(CounterY), .wrap(v_wrap), .active(v_active), .sync(vga_v_sync)
  );

  assign inDisplayArea = h_active & v_active;

endmodule
